fcmp_pipe: RTL and testbench

FCMP_PIPE -- requirements
Module: fcmp_pipe

---
 rtl/fcmp_pipe_pkg.sv | 30 +++
 rtl/fcmp_core.sv | 72 +++++++
 rtl/fcmp_pipe.sv | 90 +++++++++
 tb/tb_fcmp_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcmp_pipe_pkg.sv
// Shared FPU definitions: compare/min/max op encodings, classification bit positions, canonical NaN.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fcmp_pipe_pkg;

  typedef enum logic [2:0] {
    OP_FEQ  = 3'd0,
    OP_FLT  = 3'd1,
    OP_FLE  = 3'd2,
    OP_FMIN = 3'd3,
    OP_FMAX = 3'd4
  } fcmp_op_e;

  // Bit positions inside a per-operand classification vector
  localparam int CLS_ZERO = 0;
  localparam int CLS_NAN  = 1;
  localparam int CLS_NEG  = 2;
  localparam int CLS_W    = 3;

  localparam int FP_MAX_W = 64;

  // Quiet NaN with positive sign: exponent all ones, mantissa MSB set, rest clear
  function automatic logic [FP_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational float compare/min/max with denormal flush and NaN handling.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module fcmp_core
  import fcmp_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic         nv
);

  localparam logic [W-1:0] CNAN = W'(canon_nan(EXP_W, MAN_W));

  function automatic logic [CLS_W-1:0] classify(input logic [W-1:0] x);
    logic [CLS_W-1:0] k;
    k           = '0;
    k[CLS_ZERO] = ~|x[W-2:MAN_W];
    k[CLS_NAN]  = (&x[W-2:MAN_W]) & (|x[MAN_W-1:0]);
    // a flushed zero is never negative so that +0 == -0 falls out of the ordering
    k[CLS_NEG]  = x[W-1] & ~k[CLS_ZERO];
    return k;
  endfunction

  logic [CLS_W-1:0] ca, cb;
  logic [W-2:0]     ma, mb;
  logic             any_nan, eq, lt, is_min;

  always_comb begin
    ca      = classify(a);
    cb      = classify(b);
    ma      = ca[CLS_ZERO] ? '0 : a[W-2:0];
    mb      = cb[CLS_ZERO] ? '0 : b[W-2:0];
    any_nan = ca[CLS_NAN] | cb[CLS_NAN];
    eq      = (ma == mb) && (ca[CLS_NEG] == cb[CLS_NEG]);
    if (ca[CLS_NEG] != cb[CLS_NEG]) lt = ca[CLS_NEG];
    else if (ca[CLS_NEG])           lt = ma > mb;
    else                            lt = ma < mb;
    is_min = (op == OP_FMIN);

    c  = '0;
    nv = 1'b0;
    case (op)
      OP_FEQ: c[0] = eq & ~any_nan;
      OP_FLT: begin
        c[0] = lt & ~any_nan;
        nv   = any_nan;
      end
      OP_FLE: begin
        c[0] = (lt | eq) & ~any_nan;
        nv   = any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        if (ca[CLS_NAN] && cb[CLS_NAN]) begin
          c  = CNAN;
          nv = 1'b1;
        end else if (ca[CLS_NAN]) c = b;
        else if (cb[CLS_NAN])     c = a;
        // equal values: pick by raw sign so min prefers -0 and max prefers +0
        else if (eq)              c = (is_min == a[W-1]) ? a : b;
        else                      c = (lt == is_min) ? a : b;
      end
      default: nv = 1'b1;
    endcase
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Valid/ready pipeline around fcmp_core; each stage holds a valid bit and advances when its successor can take it.
// Latency: STAGES cycles from acceptance to out_valid without stall; one result per cycle.
// Backpressure: out_ready ripples combinationally back to in_ready; a stalled output holds c/nv/out_valid stable.
module fcmp_pipe
  import fcmp_pipe_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 1,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         nv
);

  logic [W-1:0] core_c;
  logic         core_nv;

  fcmp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
    .op (op),
    .a  (a),
    .b  (b),
    .c  (core_c),
    .nv (core_nv)
  );

  for (genvar g = 0; g < STAGES; g++) begin : stg
    logic         vld, adv, nxt_adv, pv, pnv;
    logic [W-1:0] dat, pdat;
    logic         nvr;

    if (g == 0) begin : g_src_in
      assign pv   = in_valid;
      assign pdat = core_c;
      assign pnv  = core_nv;
    end else begin : g_src_prev
      assign pv   = stg[g-1].vld;
      assign pdat = stg[g-1].dat;
      assign pnv  = stg[g-1].nvr;
    end

    if (g == STAGES - 1) begin : g_adv_out
      assign nxt_adv = out_ready;
    end else begin : g_adv_next
      assign nxt_adv = stg[g+1].adv;
    end

    assign adv = !vld || nxt_adv;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      vld <= 1'b0;
      else if (adv) vld <= pv;
    end

    // only the output stage is reset so c/nv read zero until the first result
    if (g == STAGES - 1) begin : g_dat_out
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dat <= '0;
          nvr <= 1'b0;
        end else if (adv && pv) begin
          dat <= pdat;
          nvr <= pnv;
        end
      end
    end else begin : g_dat_mid
      always_ff @(posedge clk) begin
        if (adv && pv) begin
          dat <= pdat;
          nvr <= pnv;
        end
      end
    end
  end

  assign in_ready  = stg[0].adv;
  assign out_valid = stg[STAGES-1].vld;
  assign c         = stg[STAGES-1].dat;
  assign nv        = stg[STAGES-1].nvr;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: STAGES=1 instance for directed results and exact latency, STAGES=3 for stall, order and reset.
// Scoreboard model orders operands as signed integers and checks every valid output cycle.
module tb_fcmp_pipe;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, nv1;
  logic [2:0]   op1;
  logic [W-1:0] a1, b1, c1;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, nv3;
  logic [2:0]   op3;
  logic [W-1:0] a3, b3, c3;

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .op(op1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .c(c1), .nv(nv1)
  );

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .op(op3), .a(a3), .b(b3),
    .out_valid(out_valid3), .out_ready(out_ready3), .c(c3), .nv(nv3)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out1 = 0;
  int n_out3 = 0;
  bit saw_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ordering key: flushed zero -> 0, otherwise signed magnitude as an integer
  function automatic longint key(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0;
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction

  // returns {nv, c}
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit na, nb;
    longint va, vb;
    logic [32:0] r;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    va = key(a);
    vb = key(b);
    r  = '0;
    case (op)
      3'd0: r[0] = !na && !nb && (va == vb);
      3'd1: begin r[32] = na || nb; r[0] = !(na || nb) && (va < vb); end
      3'd2: begin r[32] = na || nb; r[0] = !(na || nb) && (va <= vb); end
      3'd3, 3'd4: begin
        if (na && nb)      r = {1'b1, 32'h7FC00000};
        else if (na)       r = {1'b0, b};
        else if (nb)       r = {1'b0, a};
        else if (va == vb) r = {1'b0, (op == 3'd3) ? (a[31] ? a : b) : (a[31] ? b : a)};
        else if ((va < vb) == (op == 3'd3)) r = {1'b0, a};
        else               r = {1'b0, b};
      end
      default: r = {1'b1, 32'h0};
    endcase
    return r;
  endfunction

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } vec_t;
  typedef struct { logic [32:0] r; int t; } exp_t;
  vec_t vecs[$];
  exp_t q1[$];
  exp_t q3[$];

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q3.delete();
      chk("rst_out_valid3", {63'd0, out_valid3}, 64'd0);
      chk("rst_c3_nv3", {31'd0, nv3, c3}, 64'd0);
      chk("rst_out_valid1", {63'd0, out_valid1}, 64'd0);
      chk("rst_c1_nv1", {31'd0, nv1, c1}, 64'd0);
    end else begin
      if (out_valid1) begin
        if (q1.size() == 0) chk("dut1_spurious_output", 64'd1, 64'd0);
        else begin
          chk("dut1_result", {31'd0, nv1, c1}, {31'd0, q1[0].r});
          chk("dut1_latency", 64'(cyc - q1[0].t), 64'd1);
          if (out_ready1) begin
            void'(q1.pop_front());
            n_out1++;
          end
        end
      end
      if (in_valid1 && in_ready1) q1.push_back('{model(op1, a1, b1), cyc});
      if (out_valid3) begin
        if (q3.size() == 0) chk("dut3_spurious_output", 64'd1, 64'd0);
        else begin
          chk("dut3_result", {31'd0, nv3, c3}, {31'd0, q3[0].r});
          chk("dut3_latency_min", {63'd0, (cyc - q3[0].t) >= 3}, 64'd1);
          if (out_ready3) begin
            void'(q3.pop_front());
            n_out3++;
          end
        end
      end
      if (in_valid3 && in_ready3) q3.push_back('{model(op3, a3, b3), cyc});
      if (in_valid3 && !in_ready3) saw_full = 1'b1;
    end
  end

  task automatic send3(input vec_t v);
    bit ok;
    int n;
    in_valid3 = 1'b1;
    op3 = v.op;
    a3  = v.a;
    b3  = v.b;
    n   = 0;
    do begin
      @(negedge clk);
      ok = in_ready3;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send3_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain3(input string name);
    int n;
    n = 0;
    while (q3.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, 64'(q3.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0;
    in_valid1 = 1'b0; op1 = '0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
    in_valid3 = 1'b0; op3 = '0; a3 = '0; b3 = '0; out_ready3 = 1'b1;

    vecs.push_back('{3'd1, 32'h3F800000, 32'h40000000});
    vecs.push_back('{3'd0, 32'h80000000, 32'h00000000});
    vecs.push_back('{3'd1, 32'h80000000, 32'h00000000});
    vecs.push_back('{3'd2, 32'h7FC00000, 32'h3F800000});
    vecs.push_back('{3'd4, 32'h7FC00000, 32'h3F800000});
    vecs.push_back('{3'd3, 32'h7FC00000, 32'h7FC00001});
    vecs.push_back('{3'd3, 32'hC0000000, 32'hBF800000});
    vecs.push_back('{3'd4, 32'h80000000, 32'h00000000});
    vecs.push_back('{3'd3, 32'h00000000, 32'h80000000});
    vecs.push_back('{3'd0, 32'h7FC00000, 32'h7FC00000});
    vecs.push_back('{3'd1, 32'h7F800000, 32'h7F7FFFFF});
    vecs.push_back('{3'd1, 32'hFF800000, 32'h00000001});
    vecs.push_back('{3'd0, 32'h00000001, 32'h80000000});
    vecs.push_back('{3'd2, 32'h3F800000, 32'h3F800000});
    vecs.push_back('{3'd5, 32'h3F800000, 32'h3F800000});
    vecs.push_back('{3'd7, 32'h00000000, 32'h00000000});
    vecs.push_back('{3'd4, 32'hBF800000, 32'hC0000000});
    vecs.push_back('{3'd3, 32'h00400000, 32'h80000000});

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready1_after_rst", {63'd0, in_ready1}, 64'd1);
    chk("in_ready3_after_rst", {63'd0, in_ready3}, 64'd1);

    // hand-computed anchors for the model
    chk("model_flt_1_2", 64'(model(3'd1, 32'h3F800000, 32'h40000000)), 64'h0_00000001);
    chk("model_feq_pm0", 64'(model(3'd0, 32'h80000000, 32'h00000000)), 64'h0_00000001);
    chk("model_flt_pm0", 64'(model(3'd1, 32'h80000000, 32'h00000000)), 64'h0_00000000);
    chk("model_fle_nan", 64'(model(3'd2, 32'h7FC00000, 32'h3F800000)), 64'h1_00000000);
    chk("model_fmax_nan", 64'(model(3'd4, 32'h7FC00000, 32'h3F800000)), 64'h0_3F800000);
    chk("model_fmin_2nan", 64'(model(3'd3, 32'h7FC00000, 32'h7FC00001)), 64'h1_7FC00000);
    chk("model_fmin_neg", 64'(model(3'd3, 32'hC0000000, 32'hBF800000)), 64'h0_C0000000);
    chk("model_fmax_pm0", 64'(model(3'd4, 32'h80000000, 32'h00000000)), 64'h0_00000000);
    chk("model_fmin_pm0", 64'(model(3'd3, 32'h00000000, 32'h80000000)), 64'h0_80000000);
    chk("model_reserved", 64'(model(3'd6, 32'h3F800000, 32'h3F800000)), 64'h1_00000000);

    // STAGES=1: back-to-back directed stream, always ready
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      in_valid1 = 1'b1;
      op1 = vecs[i].op;
      a1  = vecs[i].a;
      b1  = vecs[i].b;
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dut1_drained", 64'(q1.size()), 64'd0);
    chk("dut1_count", 64'(n_out1), 64'(vecs.size()));

    // STAGES=3: 8 back-to-back requests with out_ready low for cycles 4-6
    @(posedge clk);
    #1;
    base = n_out3;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready3 = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready3 = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) send3(vecs[i + 4]);
    in_valid3 = 1'b0;
    drain3("dut3_burst_drained");
    chk("dut3_burst_count", 64'(n_out3 - base), 64'd8);
    chk("dut3_in_ready_dropped", {63'd0, saw_full}, 64'd1);

    // reset with two requests in flight
    @(posedge clk);
    #1;
    send3(vecs[0]);
    send3(vecs[1]);
    in_valid3 = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid3", {63'd0, out_valid3}, 64'd1);
    base = n_out3;
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid3", {63'd0, out_valid3}, 64'd0);
    chk("rst_async_c3", {32'd0, c3}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready3_after_mid_rst", {63'd0, in_ready3}, 64'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("no_result_after_rst", 64'(n_out3 - base), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
